// File: rtl/multdiv_step_counter.sv
// Step sequencer for the iterative multiply/divide datapath: a WIDTH-bit step
// counter with runtime terminal count, stall, restart/clear and one-shot or wrap modes.
module multdiv_step_counter #(
  parameter int WIDTH = 5
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] limit,
  input  logic             mode_wrap,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             last,
  output logic             done,
  output logic             wrap_pulse
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic             wrap_q, wrap_d;
  logic             wrap_pulse_q, wrap_pulse_d;
  logic             at_limit;

  assign at_limit = (count_q == limit_q);

  // Priority: clear > start > enable; reset is handled in the register process.
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    limit_d      = limit_q;
    wrap_d       = wrap_q;
    wrap_pulse_d = 1'b0;

    if (clear) begin
      state_d = IDLE;
      count_d = '0;
    end else if (start) begin
      state_d = RUN;
      count_d = '0;
      limit_d = limit;
      wrap_d  = mode_wrap;
    end else begin
      case (state_q)
        IDLE: begin
          count_d = '0;
        end
        RUN: begin
          if (enable) begin
            if (at_limit) begin
              if (wrap_q) begin
                count_d      = '0;
                wrap_pulse_d = 1'b1;
              end else begin
                // Count parks on the terminal index for the DONE cycle.
                state_d = DONE;
              end
            end else begin
              count_d = count_q + WIDTH'(1);
            end
          end
        end
        DONE: begin
          state_d = IDLE;
          count_d = '0;
        end
        default: begin
          state_d = IDLE;
          count_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      count_q      <= '0;
      limit_q      <= '0;
      wrap_q       <= 1'b0;
      wrap_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      limit_q      <= limit_d;
      wrap_q       <= wrap_d;
      wrap_pulse_q <= wrap_pulse_d;
    end
  end

  assign count      = count_q;
  assign busy       = (state_q == RUN);
  assign last       = busy && at_limit;
  assign done       = (state_q == DONE);
  assign wrap_pulse = wrap_pulse_q;

endmodule

// File: tb/tb_multdiv_step_counter.sv
// Self-checking bench for multdiv_step_counter: directed scenarios plus random
// traffic, all compared against a behavioural sequence model.
module tb_multdiv_step_counter;
  localparam int W = 5;
  localparam int MAXV = (1 << W) - 1;

  logic         clock = 1'b0;
  logic         reset_n, start, clear, enable, mode_wrap;
  logic [W-1:0] limit;
  logic [W-1:0] count;
  logic         busy, last, done, wrap_pulse;

  int errors = 0;
  int checks = 0;

  // Behavioural model: phase 0=idle, 1=counting, 2=finished-this-cycle
  int m_phase, m_cnt, m_lim, m_pulse;
  bit m_wrap;

  multdiv_step_counter #(.WIDTH(W)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .clear(clear),
    .enable(enable), .limit(limit), .mode_wrap(mode_wrap),
    .count(count), .busy(busy), .last(last), .done(done), .wrap_pulse(wrap_pulse)
  );

  always #5 clock = ~clock;

  function automatic logic [W+3:0] got_v();
    return {busy, last, done, wrap_pulse, count};
  endfunction

  function automatic logic [W+3:0] exp_v();
    logic b;
    logic [W-1:0] c;
    b = (m_phase == 1);
    c = W'(m_cnt);
    return {b, b && (m_cnt == m_lim), m_phase == 2, m_pulse != 0, c};
  endfunction

  task automatic model_edge(input bit rn, st, cl, en, input int lim, input bit mw);
    m_pulse = 0;
    if (!rn) begin
      m_phase = 0; m_cnt = 0; m_lim = 0; m_wrap = 0;
    end else if (cl) begin
      m_phase = 0; m_cnt = 0;
    end else if (st) begin
      m_phase = 1; m_cnt = 0; m_lim = lim; m_wrap = mw;
    end else if (m_phase == 2) begin
      m_phase = 0; m_cnt = 0;
    end else if (m_phase == 1 && en) begin
      if (m_cnt < m_lim) m_cnt = m_cnt + 1;
      else if (m_wrap) begin m_cnt = 0; m_pulse = 1; end
      else m_phase = 2;
    end
  endtask

  task automatic drive(input bit rn, st, cl, en, input int lim, input bit mw);
    @(negedge clock);
    reset_n = rn; start = st; clear = cl; enable = en;
    limit = W'(lim); mode_wrap = mw;
    @(posedge clock);
    model_edge(rn, st, cl, en, lim, mw);
    #1;
  endtask

  task automatic test_reset();
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 1, 7, 1);
    checks++;
    if (got_v() !== '0) begin
      errors++; $display("FAIL reset_hold got=%h exp=0", got_v());
    end
    drive(1, 0, 0, 1, 7, 0);
    checks++;
    if (got_v() !== exp_v() || got_v() !== '0) begin
      errors++; $display("FAIL reset_release got=%h exp=%h", got_v(), exp_v());
    end
  endtask

  task automatic test_oneshot();
    int dones = 0;
    int mism = 0;
    drive(1, 1, 0, 1, MAXV, 0);
    for (int k = 0; k < 34; k++) begin
      checks++;
      if (got_v() !== exp_v()) begin
        errors++; mism++;
        if (mism < 5) $display("FAIL oneshot_cyc%0d got=%h exp=%h", k, got_v(), exp_v());
      end
      if (done) begin
        dones++;
        checks++;
        if (count !== W'(MAXV)) begin
          errors++; $display("FAIL oneshot_done_count got=%0d exp=%0d", count, MAXV);
        end
      end
      drive(1, 0, 0, 1, 0, 0);
    end
    checks++;
    if (dones != 1) begin
      errors++; $display("FAIL oneshot_done_pulses got=%0d exp=1", dones);
    end
  endtask

  task automatic test_stall();
    bit en_pat [6] = '{1, 0, 0, 1, 1, 1};
    int exp_cnt [5] = '{1, 1, 1, 2, 3};
    drive(1, 1, 0, 0, 3, 0);
    for (int k = 0; k < 6; k++) begin
      drive(1, 0, 0, en_pat[k], 9, 1);
      checks++;
      if (got_v() !== exp_v()) begin
        errors++; $display("FAIL stall_cyc%0d got=%h exp=%h", k, got_v(), exp_v());
      end
      if (k < 5) begin
        checks++;
        if (count !== W'(exp_cnt[k]) || busy !== 1'b1) begin
          errors++; $display("FAIL stall_seq%0d got=%0d/%b exp=%0d/1", k, count, busy, exp_cnt[k]);
        end
      end
    end
    checks++;
    if (done !== 1'b1 || count !== W'(3)) begin
      errors++; $display("FAIL stall_done got=%b/%0d exp=1/3", done, count);
    end
    drive(1, 0, 0, 0, 0, 0);
  endtask

  task automatic test_wrap();
    int pulses = 0;
    drive(1, 1, 0, 1, 2, 1);
    for (int k = 0; k < 9; k++) begin
      drive(1, 0, 0, 1, 0, 0);
      checks++;
      if (got_v() !== exp_v() || done !== 1'b0 || busy !== 1'b1) begin
        errors++; $display("FAIL wrap_cyc%0d got=%h exp=%h", k, got_v(), exp_v());
      end
      if (wrap_pulse) pulses++;
    end
    checks++;
    if (pulses != 3) begin
      errors++; $display("FAIL wrap_pulses got=%0d exp=3", pulses);
    end
    drive(1, 0, 1, 0, 0, 0);
  endtask

  task automatic test_restart();
    drive(1, 1, 0, 1, 9, 0);
    for (int k = 0; k < 5; k++) drive(1, 0, 0, 1, 0, 0);
    checks++;
    if (count !== W'(5)) begin
      errors++; $display("FAIL restart_pre got=%0d exp=5", count);
    end
    drive(1, 1, 0, 1, 2, 0);
    checks++;
    if (got_v() !== exp_v() || count !== '0 || busy !== 1'b1) begin
      errors++; $display("FAIL restart_zero got=%h exp=%h", got_v(), exp_v());
    end
    for (int k = 0; k < 3; k++) drive(1, 0, 0, 1, 0, 0);
    checks++;
    if (done !== 1'b1 || count !== W'(2)) begin
      errors++; $display("FAIL restart_resample got=%b/%0d exp=1/2", done, count);
    end
    drive(1, 1, 0, 1, 4, 0);
    checks++;
    if (busy !== 1'b1 || count !== '0 || done !== 1'b0) begin
      errors++; $display("FAIL start_in_done got=%h exp=%h", got_v(), exp_v());
    end
    drive(1, 1, 1, 1, 4, 0);
    checks++;
    if (got_v() !== '0) begin
      errors++; $display("FAIL clear_with_start got=%h exp=0", got_v());
    end
  endtask

  task automatic test_edges();
    drive(1, 1, 0, 0, 0, 0);
    checks++;
    if (last !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL lim0_last got=%b exp=1", last);
    end
    drive(1, 0, 0, 1, 0, 0);
    checks++;
    if (done !== 1'b1 || count !== '0) begin
      errors++; $display("FAIL lim0_done got=%b exp=1", done);
    end
    drive(1, 1, 0, 1, 0, 1);
    for (int k = 0; k < 3; k++) begin
      drive(1, 0, 0, 1, 0, 0);
      checks++;
      if (wrap_pulse !== 1'b1 || count !== '0 || busy !== 1'b1) begin
        errors++; $display("FAIL lim0_wrap%0d got=%h exp=%h", k, got_v(), exp_v());
      end
    end
    drive(1, 1, 0, 1, 4, 0);
    for (int k = 0; k < 5; k++) drive(1, 0, 0, 1, 1, 1);
    checks++;
    if (done !== 1'b1 || count !== W'(4)) begin
      errors++; $display("FAIL limit_change got=%b/%0d exp=1/4", done, count);
    end
    drive(1, 1, 0, 1, 6, 0);
    for (int k = 0; k < 3; k++) drive(1, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 1, 0, 0);
    checks++;
    if (got_v() !== '0) begin
      errors++; $display("FAIL reset_midrun got=%h exp=0", got_v());
    end
    drive(1, 0, 0, 1, 0, 0);
    checks++;
    if (got_v() !== '0) begin
      errors++; $display("FAIL reset_midrun_after got=%h exp=0", got_v());
    end
  endtask

  task automatic test_random();
    int mism = 0;
    for (int k = 0; k < 400; k++) begin
      bit rn, st, cl, en, mw;
      int lim;
      rn  = ($urandom_range(99) != 0);
      cl  = ($urandom_range(49) == 0);
      st  = ($urandom_range(11) == 0);
      en  = ($urandom_range(3) != 0);
      mw  = $urandom_range(1);
      lim = ($urandom_range(3) == 0) ? $urandom_range(MAXV) : $urandom_range(5);
      drive(rn, st, cl, en, lim, mw);
      checks++;
      if (got_v() !== exp_v()) begin
        errors++; mism++;
        if (mism < 5) $display("FAIL random_cyc%0d got=%h exp=%h", k, got_v(), exp_v());
      end
    end
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; clear = 1'b0; enable = 1'b0;
    limit = '0; mode_wrap = 1'b0;
    m_phase = 0; m_cnt = 0; m_lim = 0; m_wrap = 0; m_pulse = 0;
    test_reset();
    test_oneshot();
    test_stall();
    test_wrap();
    test_restart();
    test_edges();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multdiv_step_counter.md
Name: multdiv_step_counter

Overview:
Parametrised step sequencer for the iterative multiplier/divider datapath. It replaces the fixed 3-bit, 8-state cycle counter with a WIDTH-bit counter that has the following features:
- runtime terminal count
- start/restart and clear controls
- stall (enable)
- one-shot or wrap mode
- registered done and wrap pulses
The multdiv control FSM uses it to count iteration steps and detect the final step.

Parameters:
WIDTH, 5, counter and limit width in bits; the maximum step index is 2^WIDTH-1. Default covers 32 iterations.

Ports:
clock  input  1  rising-edge clock for all state
reset_n  input  1  synchronous active-low reset, sampled on rising edge of clock
start  input  1  begin, or restart, a count sequence; samples limit and mode_wrap
clear  input  1  synchronous abort to IDLE
enable  input  1  advance one step this cycle (0 = stall, hold count)
limit  input  WIDTH  terminal step index; sampled only when start is accepted
mode_wrap  input  1  0 = one-shot, 1 = wrap/free-run; sampled with limit
count  output  WIDTH  current step index (registered)
busy  output  1  high while state is RUN
last  output  1  combinational: busy && (count == limit_q)
done  output  1  one-cycle pulse, high exactly while state is DONE
wrap_pulse  output  1  registered one-cycle pulse when a wrap occurs

Behaviour:
- Interface (decided): one clock, `clock`; reset `reset_n` is synchronous and active-low. There is no asynchronous path.
- State machine and internal registers:
  - States: IDLE, RUN, DONE.
  - Internal registers: limit_q[WIDTH-1:0] and wrap_q, loaded only when start is accepted.
- Control priority at each rising edge: reset_n low > clear > start > enable.
- Reset (reset_n=0): state=IDLE, count=0, limit_q=0, wrap_q=0, wrap_pulse=0. Hence busy=0, last=0, done=0. Reset applied mid-RUN or in DONE aborts immediately, with no done or wrap_pulse.
- clear=1 (reset_n=1), any state: same result as reset, except limit_q and wrap_q may hold their values. No pulse is generated.
- start=1 (no reset or clear), any state:
  - state goes to RUN, count=0, limit_q=limit, wrap_q=mode_wrap, wrap_pulse=0.
  - Start in RUN is a restart; the in-flight sequence is discarded with no done.
  - Start in DONE begins the next sequence back-to-back.
- IDLE with no start: count holds 0.
- RUN, enable=0: count and state hold. Pulses are 0.
- RUN, enable=1, count != limit_q: count <= count+1.
- RUN, enable=1, count == limit_q:
  - wrap_q=0: state goes to DONE, count holds limit_q, done is high for that one cycle.
  - wrap_q=1: count goes to 0, wrap_pulse=1 for one cycle, state stays RUN.
- DONE lasts exactly one cycle. Next edge goes to IDLE with count=0, unless start is asserted (then RUN).
- Latency: with enable held high, start accepted at edge E and limit=L gives count=k after edge E+k (k = 0..L). done is high after edge E+L+1, i.e. L+1 enabled steps. Each stalled cycle adds one cycle.
- limit=0:
  - last is high from the first RUN cycle.
  - One-shot: DONE after the first enabled cycle.
  - Wrap: wrap_pulse on every enabled cycle, count stays 0.
- limit=2^WIDTH-1: count reaches all-ones with no overflow, because the increment never happens past limit_q.
- Changes on limit or mode_wrap while in RUN have no effect until the next accepted start.
- Arithmetic: count is unsigned WIDTH-bit. The increment result is truncated to WIDTH bits, but the increment is never taken at all-ones.

Test Plan:
1. Reset with WIDTH=5: hold reset_n=0 for 2 cycles, then release -> count=0, busy=0, done=0, wrap_pulse=0. Pulsing start with reset_n=0 -> still IDLE.
2. One-shot, limit=31, enable=1, start pulse at edge 0 -> count=0..31 on edges 0..31; last high only at count=31; done high for exactly one cycle after edge 32, with count=31; IDLE with count=0 after edge 33.
3. Stall: limit=3, enable pattern 1,0,0,1,1,1 after start -> count sequence 1,1,1,2,3 then DONE. done appears 2 cycles later than unstalled; busy stays high throughout the stall.
4. Wrap mode, limit=2, enable=1 for 9 cycles -> count 0,1,2,0,1,2,0,1,2; wrap_pulse high on each cycle where count returns to 0 after 2; done never asserts; busy stays 1.
5. Restart and clear:
   - start at count=5 (limit=9) -> count=0 next cycle, limit re-sampled, no done.
   - clear together with start -> IDLE, count=0.
   - start in the DONE cycle -> RUN with count=0 and no IDLE gap.
6. Edge cases:
   - limit=0 one-shot -> done after one enabled cycle.
   - limit changed to 1 mid-RUN with limit_q=4 -> still counts to 4.
   - reset_n=0 at count=3 -> IDLE with no done pulse.
